// File: rtl/noc_tx_arb.sv
// noc_tx_arb: arbitrates NREQ byte-stream requesters onto one registered
// NoC byte channel (ctl + data). The winner keeps the channel until its
// last byte is accepted. Gaps inside a frame are sent as filler bytes
// (ctl=0, data=00) and flagged on underrun_err.
// Build option: define NOC_TX_RR_EN for round-robin arbitration. Without
// it, the lowest index wins.
module noc_tx_arb #(
  parameter int unsigned NREQ = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   vld,
  input  logic [8*NREQ-1:0] data,
  input  logic [NREQ-1:0]   last,
  output logic [NREQ-1:0]   rdy,
  output logic              noc_from_dev_ctl,
  output logic [7:0]        noc_from_dev_data,
  output logic [1:0]        gnt_id,
  output logic              busy,
  output logic              underrun_err
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        first_q, first_d;
  logic        ctl_q, ctl_d;
  logic [7:0]  data_q, data_d;
  logic        uerr_q, uerr_d;
`ifdef NOC_TX_RR_EN
  logic [1:0]  ptr_q, ptr_d;
`endif

  logic [NREQ-1:0] own_oh;
  logic            own_req, own_vld, own_last;
  logic [7:0]      own_data;
  logic [1:0]      win;
  logic            found;
  int unsigned     idx;

  // Select the current owner's request, handshake and byte.
  always_comb begin
    own_oh   = '0;
    own_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      own_oh[i] = (gnt_q == 2'(i));
      if (own_oh[i]) own_data = data[8*i +: 8];
    end
    own_req  = |(req  & own_oh);
    own_vld  = |(vld  & own_oh);
    own_last = |(last & own_oh);
  end

  // Pick a winner: scan from the pointer (round-robin) or from index 0.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef NOC_TX_RR_EN
      idx = (32'(ptr_q) + k) % NREQ;
`else
      idx = k;
`endif
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!found && j == idx && req[j]) begin
          win   = 2'(j);
          found = 1'b1;
        end
      end
    end
  end

  // Next-state, accept strobes and the next NoC byte.
  // A dropped req on the owner counts as an underrun, just like a low vld.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    first_d = first_q;
    ctl_d   = 1'b1;
    data_d  = '0;
    uerr_d  = 1'b0;
    rdy     = '0;
`ifdef NOC_TX_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = win;
          first_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        rdy = own_oh;
        if (own_vld && own_req) begin
          ctl_d   = first_q;
          data_d  = own_data;
          first_d = 1'b0;
          if (own_last) begin
            state_d = IDLE;
`ifdef NOC_TX_RR_EN
            ptr_d   = (gnt_q == 2'(NREQ-1)) ? '0 : gnt_q + 2'd1;
`endif
          end
        end else begin
          ctl_d  = 1'b0;
          uerr_d = 1'b1;
        end
      end
    endcase
  end

  // State and output registers; reset forces IDLE and a NOP on the channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      first_q <= 1'b0;
      ctl_q   <= 1'b1;
      data_q  <= '0;
      uerr_q  <= 1'b0;
`ifdef NOC_TX_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      first_q <= first_d;
      ctl_q   <= ctl_d;
      data_q  <= data_d;
      uerr_q  <= uerr_d;
`ifdef NOC_TX_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign noc_from_dev_ctl  = ctl_q;
  assign noc_from_dev_data = data_q;
  assign gnt_id            = gnt_q;
  assign busy              = (state_q == SEND);
  assign underrun_err      = uerr_q;

endmodule
